om_otf_convert: RTL



---
 rtl/om_pkg.sv | 29 ++
 rtl/om_otf_step.sv | 45 ++++
 rtl/om_otf_convert.sv | 94 +++++++++
 3 files changed

// File: rtl/om_pkg.sv
`default_nettype none
// ============================================================================
// om_pkg : digit encodings, FSM state type and a signed-digit helper shared by
//          the on-the-fly converter and its bench.
// Rev 1.0 : initial release
// ============================================================================
package om_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Code 2'b11 is a redundant zero.
    function automatic int dig_val(input logic [1:0] code);
        case (code)
            DIG_POS: dig_val = 1;
            DIG_NEG: dig_val = -1;
            default: dig_val = 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/om_otf_step.sv
`default_nettype none
// ============================================================================
// om_otf_step : one on-the-fly conversion step, updating the Q/QM pair for a
//               single radix-2 signed digit.
// Rev 1.0 : initial release
// ============================================================================
module om_otf_step
    import om_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_qm,
    input  logic [1:0]   i_d,
    output logic [W-1:0] o_q_next,
    output logic [W-1:0] o_qm_next
);

    logic [W-1:0] w_q_sh;
    logic [W-1:0] w_qm_sh;

    assign w_q_sh  = {i_q[W-2:0],  1'b0};
    assign w_qm_sh = {i_qm[W-2:0], 1'b0};

    always_comb begin
        o_q_next  = w_q_sh;
        o_qm_next = w_qm_sh | W'(1);
        case (i_d)
            DIG_POS: begin
                o_q_next  = w_q_sh | W'(1);
                o_qm_next = w_q_sh;
            end
            DIG_NEG: begin
                o_q_next  = w_qm_sh | W'(1);
                o_qm_next = w_qm_sh;
            end
            default: begin
                o_q_next  = w_q_sh;
                o_qm_next = w_qm_sh | W'(1);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/om_otf_convert.sv
`default_nettype none
// ============================================================================
// om_otf_convert : serial MSD-first signed-digit to two's-complement converter
//                  with valid/ready input and output ports.
// Rev 1.0 : initial release
// ============================================================================
module om_otf_convert
    import om_pkg::*;
#(
    parameter int NDIG = 11,
    parameter int CW   = $clog2(NDIG+1)
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*NDIG-1:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NDIG:0]     q_out,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [2*NDIG-1:0] r_sh;
    logic [NDIG:0]     r_q;
    logic [NDIG:0]     r_qm;
    logic [CW-1:0]     r_cnt;
    logic [NDIG:0]     r_q_out;
    logic [NDIG:0]     w_q_next;
    logic [NDIG:0]     w_qm_next;
    logic              w_load;
    logic              w_last;

    assign w_load = in_valid & in_ready;
    assign w_last = (r_cnt == CW'(NDIG-1));
    assign q_out  = r_q_out;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = CONV;
            CONV:    if (w_last)   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = in_valid ? CONV : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state == CONV);
    end

    om_otf_step #(
        .W (NDIG+1)
    ) u_step (
        .i_q       (r_q),
        .i_qm      (r_qm),
        .i_d       (r_sh[1:0]),
        .o_q_next  (w_q_next),
        .o_qm_next (w_qm_next)
    );

    // QM starts at -1 so a leading -1 digit yields Q = -1 after the first step.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sh    <= '0;
            r_q     <= '0;
            r_qm    <= '1;
            r_cnt   <= '0;
            r_q_out <= '0;
        end else if (w_load) begin
            r_sh  <= z_in;
            r_q   <= '0;
            r_qm  <= '1;
            r_cnt <= '0;
        end else if (r_state == CONV) begin
            r_sh  <= r_sh >> 2;
            r_q   <= w_q_next;
            r_qm  <= w_qm_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_q_out <= w_q_next;
        end
    end

endmodule
`default_nettype wire
